// File: rtl/alu_decode_pipe_if.sv
// Instruction-in / decoded-ALU-control-out bundle for alu_decode_pipe.
// The master side drives instructions and consumes the decoded entries. The slave side is the decoder.
interface alu_decode_pipe_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic         s_bit;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         inv_b;
    logic         use_carry;
    logic         wr_en;
    logic         flags_en;
    logic         illegal;
    logic [7:0]   illegal_cnt;

    modport master (
        output in_valid, opcode, s_bit, op_a, op_b, out_ready,
        input  in_ready, out_valid, alu_ctrl, alu_a, alu_b, inv_b,
               use_carry, wr_en, flags_en, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, opcode, s_bit, op_a, op_b, out_ready,
        output in_ready, out_valid, alu_ctrl, alu_a, alu_b, inv_b,
               use_carry, wr_en, flags_en, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_decode_pipe.sv
// ARM data-processing opcode decoder feeding a DEPTH-entry FIFO of ALU control words.
// The outputs come straight from the registered head entry.
module alu_decode_pipe #(
    parameter int W         = 32,
    parameter int DEPTH     = 2,
    parameter int EXT_LOGIC = 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_decode_pipe_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]   ctrl;
        logic         inv_b;
        logic         use_carry;
        logic         wr_en;
        logic         flags_en;
        logic         illegal;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_illegal_cnt;

    entry_t          w_dec;
    entry_t          w_head;
    logic            w_swap;
    logic            w_cmp;
    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic [DEPTH-1:0] w_we;
    logic [CW-1:0]   w_count_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Decode; compares (8..11) never write Rd and always update flags.
    always_comb begin
        w_dec  = '0;
        w_swap = 1'b0;
        w_cmp  = (bus.opcode[3:2] == 2'b10);
        case (bus.opcode)
            4'd0, 4'd8:  w_dec.ctrl = 4'b0111;
            4'd1, 4'd9:  w_dec.ctrl = 4'b1001;
            4'd2, 4'd10: w_dec.ctrl = 4'b0001;
            4'd3: begin w_dec.ctrl = 4'b0001; w_swap = 1'b1; end
            4'd4, 4'd11: w_dec.ctrl = 4'b0000;
            4'd5: begin w_dec.ctrl = 4'b0000; w_dec.use_carry = 1'b1; end
            4'd6: begin w_dec.ctrl = 4'b0001; w_dec.use_carry = 1'b1; end
            4'd7: begin
                w_dec.ctrl      = 4'b0001;
                w_swap          = 1'b1;
                w_dec.use_carry = 1'b1;
            end
            4'd12: w_dec.ctrl = 4'b1000;
            4'd13: w_dec.ctrl = 4'b1010;
            4'd14: begin w_dec.ctrl = 4'b0111; w_dec.inv_b = 1'b1; end
            default: begin w_dec.ctrl = 4'b1010; w_dec.inv_b = 1'b1; end
        endcase
        w_dec.wr_en    = !w_cmp;
        w_dec.flags_en = w_cmp || bus.s_bit;
        w_dec.a        = w_swap ? bus.op_b : bus.op_a;
        w_dec.b        = w_swap ? bus.op_a : bus.op_b;
        if ((EXT_LOGIC == 0) &&
            (bus.opcode == 4'd12 || bus.opcode == 4'd14 || bus.opcode == 4'd15)) begin
            w_dec.ctrl      = 4'b0000;
            w_dec.inv_b     = 1'b0;
            w_dec.use_carry = 1'b0;
            w_dec.wr_en     = 1'b0;
            w_dec.flags_en  = 1'b0;
            w_dec.illegal   = 1'b1;
        end
    end

    assign w_in_ready  = (r_count < CW'(DEPTH));
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign w_we[gi] = w_push && (r_wr_ptr == PW'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we[i]) r_mem[i] <= w_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= w_count_next;
            if (w_push && w_dec.illegal && (r_illegal_cnt != 8'hFF))
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.alu_ctrl    = w_head.ctrl;
    assign bus.alu_a       = w_head.a;
    assign bus.alu_b       = w_head.b;
    assign bus.inv_b       = w_head.inv_b;
    assign bus.use_carry   = w_head.use_carry;
    assign bus.wr_en       = w_head.wr_en;
    assign bus.flags_en    = w_head.flags_en;
    assign bus.illegal     = w_head.illegal;
    assign bus.illegal_cnt = r_illegal_cnt;
endmodule

// File: tb/tb_alu_decode_pipe.sv
// Directed checks of alu_decode_pipe. dut0 uses the defaults and dut1 uses EXT_LOGIC=0.
module tb_alu_decode_pipe;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    alu_decode_pipe_if #(.W(32)) if0 ();
    alu_decode_pipe_if #(.W(32)) if1 ();

    alu_decode_pipe #(.W(32), .DEPTH(2), .EXT_LOGIC(1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave)
    );
    alu_decode_pipe #(.W(32), .DEPTH(2), .EXT_LOGIC(0)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        inv;
        logic        uc;
        logic        wr;
        logic        fl;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{4'd3,  1'b0, 32'd5,    32'd9,      4'b0001, 32'd9,    32'd5,      1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{4'd10, 1'b0, 32'd7,    32'd3,      4'b0001, 32'd7,    32'd3,      1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{4'd5,  1'b1, 32'h10,   32'h20,     4'b0000, 32'h10,   32'h20,     1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{4'd7,  1'b1, 32'd1,    32'd2,      4'b0001, 32'd2,    32'd1,      1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{4'd14, 1'b0, 32'hFF,   32'h0F,     4'b0111, 32'hFF,   32'h0F,     1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{4'd15, 1'b1, 32'd0,    32'hAAAA,   4'b1010, 32'd0,    32'hAAAA,   1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{4'd12, 1'b0, 32'd3,    32'd4,      4'b1000, 32'd3,    32'd4,      1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{4'd9,  1'b1, 32'hDEAD, 32'hBEEF,   4'b1001, 32'hDEAD, 32'hBEEF,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{4'd1,  1'b1, 32'h1234, 32'h8000_0001, 4'b1001, 32'h1234, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        if0.in_valid = 1'b0; if0.opcode = 4'd0; if0.s_bit = 1'b0;
        if0.op_a = '0; if0.op_b = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.opcode = 4'd0; if1.s_bit = 1'b0;
        if1.op_a = '0; if1.op_b = '0; if1.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", if0.out_valid, 1'b0);
        chk("rst_in_ready", if0.in_ready, 1'b1);
        chk("rst_illegal_cnt", if0.illegal_cnt, 8'd0);
        chk("rst_alu_ctrl", if0.alu_ctrl, 4'd0);
        chk("rst_wr_en", if0.wr_en, 1'b0);

        // One instruction at a time, consumed the cycle after it appears
        if0.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if0.in_valid = 1'b1;
            if0.opcode   = vecs[i].op;
            if0.s_bit    = vecs[i].s;
            if0.op_a     = vecs[i].a;
            if0.op_b     = vecs[i].b;
            tick();
            if0.in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), if0.out_valid, 1'b1);
            chk($sformatf("v%0d_alu_ctrl", i), if0.alu_ctrl, vecs[i].ctrl);
            chk($sformatf("v%0d_alu_a", i), if0.alu_a, vecs[i].ea);
            chk($sformatf("v%0d_alu_b", i), if0.alu_b, vecs[i].eb);
            chk($sformatf("v%0d_inv_b", i), if0.inv_b, vecs[i].inv);
            chk($sformatf("v%0d_use_carry", i), if0.use_carry, vecs[i].uc);
            chk($sformatf("v%0d_wr_en", i), if0.wr_en, vecs[i].wr);
            chk($sformatf("v%0d_flags_en", i), if0.flags_en, vecs[i].fl);
            chk($sformatf("v%0d_illegal", i), if0.illegal, 1'b0);
            tick();
            chk($sformatf("v%0d_drained", i), if0.out_valid, 1'b0);
        end

        // Fill both entries with out_ready low; a third offer is refused
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b1; if0.opcode = 4'd4; if0.s_bit = 1'b0;
        if0.op_a = 32'd1; if0.op_b = 32'd2;
        tick();
        chk("full_ready_after1", if0.in_ready, 1'b1);
        if0.opcode = 4'd2; if0.op_a = 32'd3; if0.op_b = 32'd4;
        tick();
        chk("full_ready_after2", if0.in_ready, 1'b0);
        chk("full_out_valid", if0.out_valid, 1'b1);
        if0.opcode = 4'd0; if0.op_a = 32'h77; if0.op_b = 32'h88;
        tick();
        if0.in_valid = 1'b0;
        chk("full_ready_held", if0.in_ready, 1'b0);
        chk("full_head_a", if0.alu_a, 32'd1);
        chk("full_head_ctrl", if0.alu_ctrl, 4'b0000);
        if0.out_ready = 1'b1;
        tick();
        chk("drain2_a", if0.alu_a, 32'd3);
        chk("drain2_ctrl", if0.alu_ctrl, 4'b0001);
        chk("drain2_valid", if0.out_valid, 1'b1);
        tick();
        chk("drain_empty", if0.out_valid, 1'b0);
        chk("drain_ready", if0.in_ready, 1'b1);

        // Occupancy 1 with push and pop every cycle
        if0.in_valid = 1'b1; if0.opcode = 4'd4; if0.op_a = 32'd100; if0.op_b = 32'd0;
        tick();
        chk("stream_first", if0.alu_a, 32'd100);
        for (int k = 1; k <= 10; k++) begin
            if0.op_a = 32'd100 + 32'(k);
            tick();
            chk($sformatf("stream%0d_valid", k), if0.out_valid, 1'b1);
            chk($sformatf("stream%0d_a", k), if0.alu_a, 32'd100 + 32'(k));
            chk($sformatf("stream%0d_ready", k), if0.in_ready, 1'b1);
        end
        if0.in_valid = 1'b0;
        tick();
        chk("stream_end_empty", if0.out_valid, 1'b0);

        // Illegal opcode count saturation on the EXT_LOGIC=0 instance
        if1.out_ready = 1'b1;
        if1.in_valid = 1'b1; if1.opcode = 4'd15; if1.s_bit = 1'b1;
        if1.op_a = 32'd1; if1.op_b = 32'd2;
        for (int n = 1; n <= 300; n++) begin
            tick();
            chk($sformatf("ill%0d_illegal", n), if1.illegal, 1'b1);
            chk($sformatf("ill%0d_wr_en", n), if1.wr_en, 1'b0);
            chk($sformatf("ill%0d_flags_en", n), if1.flags_en, 1'b0);
            chk($sformatf("ill%0d_ctrl", n), if1.alu_ctrl, 4'b0000);
            chk($sformatf("ill%0d_cnt", n), if1.illegal_cnt, (n > 255) ? 8'd255 : 8'(n));
        end
        if1.opcode = 4'd13; if1.s_bit = 1'b0;
        tick();
        if1.in_valid = 1'b0;
        chk("ext0_mov_legal", if1.illegal, 1'b0);
        chk("ext0_mov_ctrl", if1.alu_ctrl, 4'b1010);
        chk("ext0_cnt_hold", if1.illegal_cnt, 8'd255);

        // Reset with two entries buffered; the transfer in the reset cycle is dropped
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b1; if0.opcode = 4'd4; if0.op_a = 32'h11;
        tick();
        tick();
        chk("prerst_full", if0.in_ready, 1'b0);
        chk("prerst_valid", if0.out_valid, 1'b1);
        if0.op_a = 32'h22;
        if1.in_valid = 1'b1; if1.opcode = 4'd15;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        chk("midrst_valid", if0.out_valid, 1'b0);
        chk("midrst_ready", if0.in_ready, 1'b1);
        chk("midrst_alu_a", if0.alu_a, 32'd0);
        chk("midrst_cnt1", if1.illegal_cnt, 8'd0);
        chk("midrst_valid1", if1.out_valid, 1'b0);
        tick();
        chk("postrst_ready", if0.in_ready, 1'b1);
        chk("postrst_valid", if0.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_decode_pipe.md
ALU_DECODE_PIPE -- requirements
Module: alu_decode_pipe

Interface
REQ-001 Parameter W, default 32, data operand width in bits (legal 8..64).
REQ-002 Parameter DEPTH, default 2, output buffer entries (legal 2..8, power of two not required).
REQ-003 Parameter EXT_LOGIC, default 1; when 0, opcodes ORR/BIC/MVN are illegal.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  block accepts an instruction this cycle.
REQ-008 opcode  input  4  ARM data-processing opcode (0 AND .. 15 MVN).
REQ-009 s_bit  input  1  ARM S bit.
REQ-010 op_a, op_b  input  W each  Rn value, shifted operand-2 value.
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  downstream consumes the head entry.
REQ-013 alu_ctrl  output  4  ALU control: 0000 ADD, 0001 SUB, 0111 AND, 1001 XOR, 1010 PASS_B, 1000 OR.
REQ-014 alu_a, alu_b  output  W each  ALU operands after any swap.
REQ-015 inv_b  output  1  ALU inverts operand B before the operation.
REQ-016 use_carry  output  1  ALU uses the C flag as carry-in.
REQ-017 wr_en  output  1  result written to Rd.
REQ-018 flags_en  output  1  NZCV updated.
REQ-019 illegal  output  1  opcode unsupported under current parameters.
REQ-020 illegal_cnt  output  8  saturating count of accepted illegal opcodes.

Function
REQ-021 Decode: AND 0111; EOR 1001; SUB 0001; RSB 0001 with a/b swapped; ADD 0000; ADC 0000+use_carry; SBC 0001+use_carry; RSC 0001+swap+use_carry.
REQ-022 Decode: TST 0111, TEQ 1001, CMP 0001, CMN 0000, each wr_en=0, flags_en=1 regardless of s_bit.
REQ-023 Decode: ORR 1000; MOV 1010; BIC 0111+inv_b; MVN 1010+inv_b.
REQ-024 All non-compare opcodes: wr_en=1, flags_en=s_bit.
REQ-025 Illegal opcode (EXT_LOGIC=0 and opcode 12/14/15): alu_ctrl=0000, wr_en=0, flags_en=0, inv_b=0, use_carry=0, illegal=1; entry still enqueued.
REQ-026 Swap: alu_a=op_b, alu_b=op_a; otherwise pass-through; operands are not modified in width or value.
REQ-027 Transfer in when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-028 Decoded entry stored in FIFO of DEPTH entries; outputs driven from head entry register contents.
REQ-029 Latency: instruction accepted at edge N is visible on outputs in cycle after edge N if buffer was empty.
REQ-030 in_ready=1 iff occupancy<DEPTH; depends only on registered state, not on out_ready.
REQ-031 Simultaneous push and pop with 0<occupancy<DEPTH: occupancy unchanged, order preserved.
REQ-032 Pop when empty and push when full have no effect.
REQ-033 Read/write pointers wrap from DEPTH-1 to 0.
REQ-034 Outputs other than out_valid hold last head value when empty; content is don't-care for checking.
REQ-035 illegal_cnt increments on each accepted illegal opcode, saturates at 255.
REQ-036 Occupancy count width ceil(log2(DEPTH+1)); no overflow possible.

Reset
REQ-037 rst high at an edge: occupancy 0, pointers 0, out_valid 0, illegal_cnt 0, all decoded output registers 0.
REQ-038 in_ready is 1 in the cycle after reset deasserts.
REQ-039 rst mid-operation discards all buffered entries; any transfer in that cycle is ignored.

Verification
REQ-040 After reset, push opcode 3 (RSB), op_a=5, op_b=9, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0001, alu_a=9, alu_b=5, wr_en=1.
REQ-041 Push CMP (10) with s_bit=0 -> alu_ctrl=0001, wr_en=0, flags_en=1.
REQ-042 out_ready=0, push DEPTH=2 instructions -> in_ready=0 after second; third in_valid ignored; drain yields first two in order.
REQ-043 EXT_LOGIC=0, push MVN (15) 300 times -> illegal=1 each, wr_en=0, illegal_cnt stops at 255.
REQ-044 Occupancy 1, simultaneous push and pop for 10 cycles -> out_valid constant 1, order intact, pointers wrap.
REQ-045 Occupancy 2, assert rst for one cycle -> out_valid=0, illegal_cnt=0, in_ready=1 next cycle.
